moving_sum_trig: RTL
====================

Name: moving_sum_trig

Overview:
- Downstream consumer of the RAM delay line.
- Takes the current sample qo and the n-samples-old sample qn, and keeps a running window sum: sum += qo − qn.
- Compares the sum against a programmable threshold and issues a single-cycle trigger, with sample-counted holdoff and hysteretic re-arm.
- Feeds the event/readout logic.

Parameters:
- P_NBITS_DATA, 14, width of qo/qn samples (unsigned).
- P_NBITS_ADDR, 8, delay-line address width; window length ≤ 2^P_NBITS_ADDR.
- P_NBITS_SUM, P_NBITS_DATA+P_NBITS_ADDR, width of sum and thresh.
- P_NBITS_HOLD, 16, width of holdoff counter.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  system reset; asynchronous, active-high.
- clr  in  1  synchronous clear of sum and trigger state.
- in_stb  in  1  sample strobe; qo/qn/in_valid are sampled only when high.
- in_valid  in  1  upstream delay line primed (qn meaningful).
- qo  in  P_NBITS_DATA  current sample.
- qn  in  P_NBITS_DATA  sample delayed by window length.
- thresh  in  P_NBITS_SUM  trigger threshold; static between clr pulses.
- holdoff  in  P_NBITS_HOLD  post-trigger dead time, in accepted samples.
- sum  out  P_NBITS_SUM  running window sum (registered).
- sum_stb  out  1  one-cycle pulse; sum updated this cycle.
- trig  out  1  one-cycle trigger pulse.
- armed  out  1  high when trigger FSM is in T_ARMED.

Behaviour:
- Reset (rst high, async): sum=0, sum_stb=0, trig=0, armed=0, accumulator FSM=S_PRIME, trigger FSM=T_REARM, holdoff count=0.
- Accumulator FSM, S_PRIME:
  - in_stb & !in_valid: sum <= sum + qo.
  - in_stb & in_valid: sum <= sum + qo − qn; go to S_RUN.
- Accumulator FSM, S_RUN:
  - in_stb & in_valid: sum <= sum + qo − qn.
  - in_stb & !in_valid (upstream flush/reconfig): sum <= qo; go to S_PRIME.
- No in_stb: sum holds; no update.
- Arithmetic: computed in P_NBITS_SUM+1 bits, unsigned, result truncated to P_NBITS_SUM. Upstream guarantees qn is a prior qo, so the sum never goes negative and never overflows.
- Latency: in_stb at cycle N → sum and sum_stb at N+1 → trig at N+2.
- Trigger FSM advances only on sum_stb while the accumulator is in S_RUN. The comparison uses the registered sum.
- T_ARMED: sum > thresh (strict) → trig=1 for one cycle, load holdoff counter, go to T_HOLD; if holdoff==0, go directly to T_REARM.
- T_HOLD: decrement counter per sum_stb; at count 1→0, go to T_REARM.
- T_REARM: sum ≤ thresh → T_ARMED. A sustained level above threshold never re-triggers.
- Return to S_PRIME (in_valid drop) forces the trigger FSM to T_REARM and clears the counter; no trig while priming.
- clr: sum=0, accumulator S_PRIME, trigger T_REARM, counter=0, trig=0. Takes priority over a simultaneous in_stb; that sample is discarded.
- armed is registered and reflects the T_ARMED state.

Optional Feature:
- Macro: MOVING_SUM_TRIG_PEAK_EN.
- Defined: adds outputs peak [P_NBITS_SUM] and peak_stb [1].
  - peak tracks the maximum registered sum from the trigger cycle through the end of T_HOLD.
  - peak_stb pulses for one cycle on the T_HOLD→T_REARM transition, with peak valid that cycle.
  - holdoff==0 gives peak = trigger sum, with peak_stb one cycle after trig.
  - peak resets to 0.
- Undefined: ports and logic absent; remaining behaviour identical.

Test Plan:
- Reset → sum=0, sum_stb=0, trig=0, armed=0. Then feed qo=100 strobes with in_valid low ×4, then high with qn=100 → sum 100,200,300,400,400…; sum_stb one cycle after each in_stb.
- Window 4, thresh=1000, holdoff=3, baseline 100, then qo=500 ×4 (qn lagging 4) → sum 800, 1200 (trig exactly once, two cycles after that strobe), 1600, 2000; no further trig while sum stays 2000.
- Continue: return to qo=100 → sum falls to 1600,1200,800; armed rises once sum ≤ 1000 after 3 held samples; the next step to 500 triggers again.
- clr mid-run asserted on the same cycle as in_stb → sum=0 next cycle, sample discarded, armed=0, re-prime required.
- in_valid drops for one strobe with qo=7 → sum=7, state S_PRIME, no trig until primed and re-armed.
- Max input qo=16383 for 256 samples, window 256 → sum=4194048, no wrap. With MOVING_SUM_TRIG_PEAK_EN, peak=4194048 at peak_stb.

Source files
------------

// File: rtl/moving_sum_trig.sv
// Running window sum (sum += qo - qn) with threshold trigger, sample-counted holdoff and hysteretic re-arm.
// Optional peak capture over the holdoff window is enabled by defining MOVING_SUM_TRIG_PEAK_EN.
module moving_sum_trig #(
   parameter int P_NBITS_DATA = 14,
   parameter int P_NBITS_ADDR = 8,
   parameter int P_NBITS_SUM  = P_NBITS_DATA + P_NBITS_ADDR,
   parameter int P_NBITS_HOLD = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    in_stb,
   input  logic                    in_valid,
   input  logic [P_NBITS_DATA-1:0] qo,
   input  logic [P_NBITS_DATA-1:0] qn,
   input  logic [P_NBITS_SUM-1:0]  thresh,
   input  logic [P_NBITS_HOLD-1:0] holdoff,
   output logic [P_NBITS_SUM-1:0]  sum,
   output logic                    sum_stb,
   output logic                    trig,
`ifdef MOVING_SUM_TRIG_PEAK_EN
   output logic [P_NBITS_SUM-1:0]  peak,
   output logic                    peak_stb,
`endif
   output logic                    armed
);

   localparam logic [P_NBITS_HOLD-1:0] HOLD_ZERO = {P_NBITS_HOLD{1'b0}};
   localparam logic [P_NBITS_HOLD-1:0] HOLD_ONE  = {{(P_NBITS_HOLD-1){1'b0}}, 1'b1};
   localparam logic [P_NBITS_SUM-1:0]  SUM_ZERO  = {P_NBITS_SUM{1'b0}};
   localparam logic [P_NBITS_SUM:0]    EXT_ZERO  = {(P_NBITS_SUM+1){1'b0}};

   typedef enum logic {S_PRIME = 1'b0, S_RUN = 1'b1} acc_state_t;
   typedef enum logic [1:0] {T_ARMED = 2'd0, T_HOLD = 2'd1, T_REARM = 2'd2} trig_state_t;

   acc_state_t              acc_state_r, acc_state_n;
   trig_state_t             trig_state_r, trig_state_n;
   logic [P_NBITS_SUM-1:0]  sum_r, sum_n;
   logic                    sum_stb_r, sum_stb_n;
   logic                    trig_r, trig_n;
   logic [P_NBITS_HOLD-1:0] hold_cnt_r, hold_cnt_n;
   logic [P_NBITS_SUM:0]    qo_ext_s, qn_ext_s, acc_s;
   logic                    eval_s;
`ifdef MOVING_SUM_TRIG_PEAK_EN
   logic [P_NBITS_SUM-1:0]  peak_r, peak_n;
   logic                    peak_stb_r, peak_stb_n;
   logic                    peak_pend_r, peak_pend_n;
`endif

   assign qo_ext_s = {{(P_NBITS_SUM+1-P_NBITS_DATA){1'b0}}, qo};
   assign qn_ext_s = {{(P_NBITS_SUM+1-P_NBITS_DATA){1'b0}}, qn};
   // qn only subtracts once the delay line is primed; the extra bit absorbs the intermediate carry.
   assign acc_s    = {1'b0, sum_r} + qo_ext_s - (in_valid ? qn_ext_s : EXT_ZERO);

   // Accumulator next-state and sum update
   always_comb begin
      acc_state_n = acc_state_r;
      sum_n       = sum_r;
      sum_stb_n   = 1'b0;
      if (clr) begin
         acc_state_n = S_PRIME;
         sum_n       = SUM_ZERO;
      end else if (in_stb) begin
         sum_stb_n = 1'b1;
         case (acc_state_r)
            S_PRIME: begin
               sum_n = P_NBITS_SUM'(acc_s);
               if (in_valid) begin
                  acc_state_n = S_RUN;
               end else begin
                  acc_state_n = S_PRIME;
               end
            end
            S_RUN: begin
               if (in_valid) begin
                  sum_n = P_NBITS_SUM'(acc_s);
               end else begin
                  sum_n       = P_NBITS_SUM'(qo_ext_s);
                  acc_state_n = S_PRIME;
               end
            end
            default: begin
               sum_n       = SUM_ZERO;
               acc_state_n = S_PRIME;
            end
         endcase
      end else begin
         sum_stb_n = 1'b0;
      end
   end

   // The trigger only looks at freshly registered sums from a primed window.
   assign eval_s = sum_stb_r && (acc_state_r == S_RUN);

   // Trigger FSM next-state, holdoff counting and peak tracking
   always_comb begin
      trig_state_n = trig_state_r;
      hold_cnt_n   = hold_cnt_r;
      trig_n       = 1'b0;
`ifdef MOVING_SUM_TRIG_PEAK_EN
      peak_n       = peak_r;
      peak_stb_n   = 1'b0;
      peak_pend_n  = 1'b0;
`endif
      if (clr || (acc_state_r == S_PRIME)) begin
         trig_state_n = T_REARM;
         hold_cnt_n   = HOLD_ZERO;
      end else begin
`ifdef MOVING_SUM_TRIG_PEAK_EN
         peak_stb_n = peak_pend_r;
`endif
         if (eval_s) begin
            case (trig_state_r)
               T_ARMED: begin
                  if (sum_r > thresh) begin
                     trig_n     = 1'b1;
                     hold_cnt_n = holdoff;
`ifdef MOVING_SUM_TRIG_PEAK_EN
                     peak_n      = sum_r;
                     peak_pend_n = (holdoff == HOLD_ZERO);
`endif
                     if (holdoff == HOLD_ZERO) begin
                        trig_state_n = T_REARM;
                     end else begin
                        trig_state_n = T_HOLD;
                     end
                  end else begin
                     trig_state_n = T_ARMED;
                  end
               end
               T_HOLD: begin
`ifdef MOVING_SUM_TRIG_PEAK_EN
                  peak_n = (sum_r > peak_r) ? sum_r : peak_r;
`endif
                  if (hold_cnt_r <= HOLD_ONE) begin
                     hold_cnt_n   = HOLD_ZERO;
                     trig_state_n = T_REARM;
`ifdef MOVING_SUM_TRIG_PEAK_EN
                     peak_stb_n   = 1'b1;
`endif
                  end else begin
                     hold_cnt_n = hold_cnt_r - HOLD_ONE;
                  end
               end
               T_REARM: begin
                  if (sum_r <= thresh) begin
                     trig_state_n = T_ARMED;
                  end else begin
                     trig_state_n = T_REARM;
                  end
               end
               default: begin
                  trig_state_n = T_REARM;
                  hold_cnt_n   = HOLD_ZERO;
               end
            endcase
         end else begin
            trig_state_n = trig_state_r;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_state_r  <= S_PRIME;
         trig_state_r <= T_REARM;
         sum_r        <= SUM_ZERO;
         sum_stb_r    <= 1'b0;
         trig_r       <= 1'b0;
         hold_cnt_r   <= HOLD_ZERO;
`ifdef MOVING_SUM_TRIG_PEAK_EN
         peak_r       <= SUM_ZERO;
         peak_stb_r   <= 1'b0;
         peak_pend_r  <= 1'b0;
`endif
      end else begin
         acc_state_r  <= acc_state_n;
         trig_state_r <= trig_state_n;
         sum_r        <= sum_n;
         sum_stb_r    <= sum_stb_n;
         trig_r       <= trig_n;
         hold_cnt_r   <= hold_cnt_n;
`ifdef MOVING_SUM_TRIG_PEAK_EN
         peak_r       <= peak_n;
         peak_stb_r   <= peak_stb_n;
         peak_pend_r  <= peak_pend_n;
`endif
      end
   end

   assign sum     = sum_r;
   assign sum_stb = sum_stb_r;
   assign trig    = trig_r;
   assign armed   = (trig_state_r == T_ARMED);
`ifdef MOVING_SUM_TRIG_PEAK_EN
   assign peak     = peak_r;
   assign peak_stb = peak_stb_r;
`endif

endmodule
